muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL expose: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: clear_pipeline  in  1  synchronous abort of any in-flight operation.
REQ-004 SHALL expose: mul_para  in  3  op select: 0 MUL, 1 MULH, 2 reserved (treated as MUL), 3 MULHU, 4 DIV, 5 DIVU, 6 MOD, 7 MODU.
REQ-005 SHALL expose: mul_initial  in  1  start request; sampled only while mul_ready=1.
REQ-006 SHALL expose: mul_rs0 / mul_rs1  in  32 each  operand A (multiplicand/dividend), operand B (multiplier/divisor).
REQ-007 SHALL expose: mul_ready  out  1  high = idle, able to accept a start (low = busy).
REQ-008 SHALL expose: mul_finished  out  1  result valid; held until acknowledged.
REQ-009 SHALL expose: mul_data  out  32  result; stable while mul_finished=1.
REQ-010 SHALL expose: mul_ack  in  1  consumer accepts the result.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on mul_initial, CALC->DONE after N iterations, DONE->IDLE on mul_ack.
REQ-012 SHALL latch mul_para, |A|, |B| and result signs on the accepting edge; later operand changes SHALL NOT affect the result.
REQ-013 SHALL assert mul_ready only in IDLE and mul_finished only in DONE.
REQ-014 SHALL assert mul_finished exactly N+1 cycles after the accepting edge (first cycle after the Nth iteration edge).
REQ-015 Division SHALL use radix-2 restoring iteration, one quotient bit per cycle, N=32.
REQ-016 Signed ops SHALL compute on magnitudes, then apply signs: quotient negative iff signs differ, remainder takes the dividend's sign, product negated iff signs differ (64-bit two's complement).
REQ-017 MUL SHALL return product[31:0]; MULH/MULHU SHALL return product[63:32], signed/unsigned respectively.
REQ-018 Divisor zero SHALL yield quotient 0xFFFFFFFF and remainder = dividend, with normal latency.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and MOD remainder 0.
REQ-020 mul_ack while not in DONE SHALL be ignored; mul_initial while not in IDLE SHALL be ignored.
REQ-021 mul_ack and mul_initial in the same DONE cycle SHALL return to IDLE without starting; the new start is accepted no earlier than the next cycle.
REQ-022 clear_pipeline SHALL force IDLE on the next edge from any state, clearing mul_finished; it has priority over mul_initial and mul_ack.
REQ-023 mul_data SHALL be 0 whenever mul_finished=0.

Reset
REQ-024 Reset asserted (rst=0) SHALL immediately force IDLE, mul_ready=1, mul_finished=0, mul_data=0 and clear the iteration counter and datapath registers.
REQ-025 Reset asserted mid-CALC SHALL discard the operation; after deassertion no mul_finished SHALL occur without a new mul_initial.

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN defined: multiplies (para 0,1,2,3) SHALL use a single-cycle 33x33 signed multiplier, N=1 (mul_finished 2 cycles after accept).
REQ-027 Macro undefined: multiplies SHALL use radix-2 shift-add on magnitudes, N=32 (mul_finished 33 cycles after accept); divide behaviour SHALL be identical in both builds.

Verification
REQ-028 MUL A=0xFFFFFFFD (-3), B=7 -> mul_data 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU same -> 0x00000006; latency 2 (fast) / 33 (default).
REQ-029 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; MOD -> 0xFFFFFFFF; DIVU 100/7 -> 14, MODU -> 2; mul_finished exactly 33 cycles after accept.
REQ-030 DIVU A=0x12345678, B=0 -> 0xFFFFFFFF; MODU -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-031 Hold mul_ack=0 for 10 cycles in DONE -> mul_finished and mul_data stay constant; ack -> mul_ready=1 next cycle; mul_initial in the ack cycle is ignored.
REQ-032 clear_pipeline at iteration 10 of a DIV -> IDLE next cycle, no mul_finished; an immediate MUL 6x7 -> 42.
REQ-033 rst low at iteration 5 -> outputs at reset values immediately; after release no spurious mul_finished over 40 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit (MUL/MULH/MULHU/DIV/DIVU/MOD/MODU).
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; default is radix-2 shift-add.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_pipeline,
    input  logic [2:0]  mul_para,
    input  logic        mul_initial,
    input  logic [31:0] mul_rs0,
    input  logic [31:0] mul_rs1,
    input  logic        mul_ack,
    output logic        mul_ready,
    output logic        mul_finished,
    output logic [31:0] mul_data
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] m_q, m_d;
    logic [63:0] prod_q, prod_d;
    logic        neg_q, neg_d, rneg_q, rneg_d;
    logic        is_mul, sgn, sa, sb, ge, last;
    logic [31:0] a_mag, b_mag, q_fix, r_fix;
    logic [63:0] div_step, iter, p_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_p;
`else
    logic [32:0] add_s;
`endif

    assign is_mul = ~op_q[2];

    always_comb begin
        sgn   = (mul_para == 3'd1) | (mul_para == 3'd4) | (mul_para == 3'd6);
        sa    = sgn & mul_rs0[31];
        sb    = sgn & mul_rs1[31];
        a_mag = sa ? -mul_rs0 : mul_rs0;
        b_mag = sb ? -mul_rs1 : mul_rs1;
        // prod_q holds {remainder, dividend/quotient} for divides, {acc, multiplier} for multiplies
        ge       = prod_q[63:31] >= {1'b0, m_q};
        div_step = ge ? {prod_q[62:31] - m_q, prod_q[30:0], 1'b1} : {prod_q[62:0], 1'b0};
`ifdef MULDIV_FAST_MUL_EN
        fast_p = $signed({1'b0, m_q}) * $signed({1'b0, prod_q[31:0]});
        iter   = is_mul ? fast_p : div_step;
        last   = is_mul | (cnt_q == 5'd31);
`else
        add_s = {1'b0, prod_q[63:32]} + {1'b0, prod_q[0] ? m_q : 32'd0};
        iter  = is_mul ? {add_s, prod_q[31:1]} : div_step;
        last  = cnt_q == 5'd31;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        m_d     = m_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        if (clear_pipeline) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE && mul_initial) begin
            state_d = CALC;
            cnt_d   = '0;
            op_d    = mul_para;
            m_d     = mul_para[2] ? b_mag : a_mag;
            prod_d  = {32'd0, mul_para[2] ? a_mag : b_mag};
            // a zero divisor must give an all-ones quotient regardless of dividend sign
            neg_d   = (sa ^ sb) & ~(mul_para[2] & (mul_rs1 == 32'd0));
            rneg_d  = sa;
        end else if (state_q == CALC) begin
            prod_d = iter;
            cnt_d  = cnt_q + 5'd1;
            state_d = last ? DONE : CALC;
        end else if (state_q == DONE && mul_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        p_fix        = neg_q ? -prod_q : prod_q;
        q_fix        = neg_q ? -prod_q[31:0] : prod_q[31:0];
        r_fix        = rneg_q ? -prod_q[63:32] : prod_q[63:32];
        mul_ready    = state_q == IDLE;
        mul_finished = state_q == DONE;
        mul_data     = state_q != DONE ? 32'd0 :
                       is_mul ? (op_q[0] ? p_fix[63:32] : p_fix[31:0]) :
                       (op_q[1] ? r_fix : q_fix);
    end
endmodule
